// File: rtl/cdffr_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, stall (e), flush (c) and occupancy count.
// Optional build macro CDFFR_PIPE_DATA_CLR_EN: flush also reloads the data registers with INIT.

module cdffr_pipe_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count
);
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n) 32'(count) <= DEPTH)
        else $error("cdffr_pipe: count exceeds DEPTH");
endmodule

module cdffr_pipe #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 2,
    parameter T    INIT  = '0,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c,
    input  logic          e,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  T              in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output T              out_data_o,
    output logic [CW-1:0] count_o
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("cdffr_pipe: DEPTH must be in 1..16");
    end

    logic [DEPTH-1:0] v_r;
    T                 data_r [DEPTH];
    logic [DEPTH-1:0] rdy_s;
    logic [DEPTH-1:0] src_v_s;
    T                 src_d_s [DEPTH];
    logic [CW-1:0]    count_r;
    logic             eff_s;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Ready ripples from the output end: a stage can load if it is empty or its occupant moves on.
    always_comb begin
        rdy_s = '0;
        rdy_s[DEPTH-1] = ~v_r[DEPTH-1] | out_ready_i;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy_s[i] = ~v_r[i] | rdy_s[i+1];
        end
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        src_v_s    = '0;
        src_v_s[0] = in_valid_i;
        src_d_s[0] = in_data_i;
        for (int i = 1; i < DEPTH; i++) begin
            src_v_s[i] = v_r[i-1];
            src_d_s[i] = data_r[i-1];
        end
    end

    assign eff_s       = e & ~c;
    assign in_ready_o  = rst_n & eff_s & rdy_s[0];
    assign out_valid_o = eff_s & v_r[DEPTH-1];
    assign out_data_o  = data_r[DEPTH-1];
    assign in_xfer_s   = in_valid_i & in_ready_o;
    assign out_xfer_s  = out_valid_o & out_ready_i;
    assign count_o     = count_r;

    // Valid bits: flush empties the pipe, enabled stages take their source's valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r <= '0;
        end else if (c) begin
            v_r <= '0;
        end else if (e) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i]) begin
                    v_r[i] <= src_v_s[i];
                end else begin
                    v_r[i] <= v_r[i];
                end
            end
        end else begin
            v_r <= v_r;
        end
    end

    // Data registers load only from valid sources so bubbles do not toggle them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= INIT;
            end
        end else if (c) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef CDFFR_PIPE_DATA_CLR_EN
                data_r[i] <= INIT;
`else
                data_r[i] <= data_r[i];
`endif
            end
        end else if (e) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy_s[i] && src_v_s[i]) begin
                    data_r[i] <= src_d_s[i];
                end else begin
                    data_r[i] <= data_r[i];
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= data_r[i];
            end
        end
    end

    // Occupancy tracks accepted minus delivered items; transfers are already gated by eff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (c) begin
            count_r <= '0;
        end else if (e) begin
            count_r <= count_r + CW'(in_xfer_s) - CW'(out_xfer_s);
        end else begin
            count_r <= count_r;
        end
    end

    cdffr_pipe_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count_r)
    );

endmodule
